// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write controller: FSM encoding,
// register select codes and the default data width.
package rf_ctrl_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    localparam logic SEL_R1 = 1'b0;
    localparam logic SEL_R2 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
// Read data is the head entry, available combinationally; no bypass from push to pop.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Queues register-file write requests and drains them as WRITE/VERIFY pairs, checking readback.
// Latency: accept at edge t -> RF_WR in cycle t+1, DONE in cycle t+2; REQ_READY low while queue full.
module rf_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_SEL,
    input  logic [DW-1:0]          REQ_DATA,
    output logic                   RF_SEL,
    output logic                   RF_WR,
    output logic [DW-1:0]          RF_DATA,
    input  logic [DW-1:0]          RF_RDATA,
    output logic                   DONE,
    output logic                   ERR,
    input  logic                   ERR_CLR,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   BUSY
);

    state_t        state;
    state_t        state_nxt;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW:0]   fifo_dat;
    logic          hsel;
    logic [DW-1:0] hdata;
    logic          mismatch;

    assign REQ_READY = ~fifo_full & ~RST;
    assign push      = REQ_VALID & REQ_READY;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 1)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_dat ({REQ_SEL, REQ_DATA}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (COUNT),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register is async-reset, so RF_WR drops the moment RST rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        RF_WR     = 1'b0;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_WRITE;
                    pop       = 1'b1;
                end
            end
            ST_WRITE: begin
                RF_WR     = 1'b1;
                state_nxt = ST_VERIFY;
            end
            ST_VERIFY: begin
                DONE = 1'b1;
                if (!fifo_empty) begin
                    state_nxt = ST_WRITE;
                    pop       = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding registers keep driving SEL/iData through VERIFY and IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hsel  <= SEL_R1;
            hdata <= '0;
        end else if (pop) begin
            hsel  <= fifo_dat[DW];
            hdata <= fifo_dat[DW-1:0];
        end
    end

    assign RF_SEL  = hsel;
    assign RF_DATA = hdata;
    assign BUSY    = (state != ST_IDLE) | ~fifo_empty;

    assign mismatch = (state == ST_VERIFY) && (RF_RDATA != hdata);

    // A fresh mismatch outranks a clear on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (mismatch) begin
            ERR <= 1'b1;
        end else if (ERR_CLR) begin
            ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: models the two-register file and checks write order, latency and ERR.
module tb_rf_write_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_SEL = 1'b0;
    logic [DW-1:0] REQ_DATA = '0;
    logic          ERR_CLR = 1'b0;
    logic          REQ_READY, RF_SEL, RF_WR, DONE, ERR, BUSY;
    logic [DW-1:0] RF_DATA, RF_RDATA;
    logic [CW-1:0] COUNT;

    logic          force_zero = 1'b0;
    logic [DW-1:0] rf_r1 = '0;
    logic [DW-1:0] rf_r2 = '0;

    int checks = 0;
    int errors = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc = 0, done_cnt = 0, acc_cnt = 0, mdl_cnt = 0, max_cnt = 0, aborted = 0;
    int          consec_viol = 0, rdy_viol = 0, cnt_viol = 0;
    logic        prev_wr = 1'b0, will_acc = 1'b0;
    logic [DW:0] pend = '0;

    always #5 CLK = ~CLK;

    rf_write_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_SEL   (REQ_SEL),
        .REQ_DATA  (REQ_DATA),
        .RF_SEL    (RF_SEL),
        .RF_WR     (RF_WR),
        .RF_DATA   (RF_DATA),
        .RF_RDATA  (RF_RDATA),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CLR   (ERR_CLR),
        .COUNT     (COUNT),
        .BUSY      (BUSY)
    );

    // Register file model: no reset, write on rising edge, combinational readback.
    always @(posedge CLK) begin
        if (RF_WR) begin
            if (RF_SEL) rf_r2 <= RF_DATA;
            else        rf_r1 <= RF_DATA;
        end
    end
    assign RF_RDATA = force_zero ? '0 : (RF_SEL ? rf_r2 : rf_r1);

    // Reference bookkeeping: accepted requests in order, observed writes, occupancy model.
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            mdl_cnt  = 0;
            will_acc = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            if (will_acc) begin
                exp_q.push_back(pend);
                acc_cnt++;
                mdl_cnt++;
            end
            if (RF_WR) begin
                obs_q.push_back({RF_SEL, RF_DATA});
                obs_cyc.push_back(cyc);
                mdl_cnt--;
                if (prev_wr) consec_viol++;
            end
            prev_wr = RF_WR;
            if (DONE) done_cnt++;
            if (COUNT !== CW'(mdl_cnt)) cnt_viol++;
            if (REQ_READY !== (int'(COUNT) < DEPTH)) rdy_viol++;
            if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
            will_acc = REQ_VALID && REQ_READY;
            pend     = {REQ_SEL, REQ_DATA};
        end
    end

    task automatic push_one(input logic sel, input logic [DW-1:0] dat);
        @(posedge CLK); #1;
        REQ_VALID = 1'b1; REQ_SEL = sel; REQ_DATA = dat;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({RF_WR, RF_SEL, RF_DATA, DONE, ERR, BUSY, REQ_READY, COUNT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs wr=%b sel=%b data=%h done=%b err=%b busy=%b rdy=%b cnt=%0d want all 0",
                     RF_WR, RF_SEL, RF_DATA, DONE, ERR, BUSY, REQ_READY, COUNT);
        end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", REQ_READY); end
    endtask

    task automatic test_single();
        int d0;
        clear_log();
        d0 = done_cnt;
        push_one(1'b0, 8'hA5);
        @(negedge CLK);
        checks++;
        if (RF_WR !== 1'b0 || COUNT !== CW'(1)) begin
            errors++; $display("FAIL single_queued wr=%b cnt=%0d want wr=0 cnt=1", RF_WR, COUNT);
        end
        @(negedge CLK);
        checks++;
        if ({RF_WR, RF_SEL, RF_DATA, DONE} !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL single_write wr=%b sel=%b data=%h done=%b want 1 0 a5 0", RF_WR, RF_SEL, RF_DATA, DONE);
        end
        @(negedge CLK);
        checks++;
        if ({RF_WR, DONE, ERR} !== 3'b010 || rf_r1 !== 8'hA5) begin
            errors++; $display("FAIL single_verify wr=%b done=%b err=%b r1=%h want 0 1 0 a5", RF_WR, DONE, ERR, rf_r1);
        end
        @(negedge CLK);
        checks++;
        if ({DONE, ERR, BUSY} !== 3'b000) begin
            errors++; $display("FAIL single_after done=%b err=%b busy=%b want 0 0 0", DONE, ERR, BUSY);
        end
        checks++;
        if (done_cnt - d0 != 1 || obs_q.size() != 1) begin
            errors++; $display("FAIL single_counts dones=%0d writes=%0d want 1 1", done_cnt - d0, obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [DW:0] vals[4];
        int d0;
        bit ok;
        vals[0] = 9'h011; vals[1] = 9'h122; vals[2] = 9'h033; vals[3] = 9'h144;
        clear_log();
        d0 = done_cnt;
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) begin
            REQ_VALID = 1'b1;
            {REQ_SEL, REQ_DATA} = vals[i];
            @(negedge CLK);
            checks++;
            if (REQ_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, REQ_READY); end
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        wait_idle(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout busy=%b want 0", BUSY); end
        checks++;
        if (obs_q.size() != 4) begin errors++; $display("FAIL b2b_write_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== vals[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, obs_q[i], vals[i]); end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
                errors++; $display("FAIL b2b_spacing[%0d] got %0d want 2", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        checks++;
        if (rf_r1 !== 8'h33 || rf_r2 !== 8'h44) begin
            errors++; $display("FAIL b2b_regs r1=%h r2=%h want 33 44", rf_r1, rf_r2);
        end
        checks++;
        if (done_cnt - d0 != 4) begin errors++; $display("FAIL b2b_dones got %0d want 4", done_cnt - d0); end
    endtask

    task automatic test_hold_valid();
        localparam int N = 8;
        logic [DW:0] reqs[N];
        int d0, idx;
        bit acc, ok;
        for (int i = 0; i < N; i++) reqs[i] = (DW+1)'($urandom);
        clear_log();
        max_cnt = 0;
        d0 = done_cnt;
        idx = 0;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1;
        {REQ_SEL, REQ_DATA} = reqs[0];
        for (int b = 0; b < 200 && idx < N; b++) begin
            @(negedge CLK);
            acc = REQ_READY;
            @(posedge CLK); #1;
            if (acc) begin
                idx++;
                if (idx < N) {REQ_SEL, REQ_DATA} = reqs[idx];
                else         REQ_VALID = 1'b0;
            end
        end
        REQ_VALID = 1'b0;
        checks++;
        if (idx != N) begin errors++; $display("FAIL hold_accepted got %0d want %0d", idx, N); end
        wait_idle(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_timeout busy=%b want 0", BUSY); end
        checks++;
        if (max_cnt != DEPTH) begin errors++; $display("FAIL hold_peak_count got %0d want %0d", max_cnt, DEPTH); end
        checks++;
        if (obs_q.size() != N) begin errors++; $display("FAIL hold_write_count got %0d want %0d", obs_q.size(), N); end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== reqs[i]) begin errors++; $display("FAIL hold_order[%0d] got %h want %h", i, obs_q[i], reqs[i]); end
        end
        checks++;
        if (done_cnt - d0 != N) begin errors++; $display("FAIL hold_dones got %0d want %0d", done_cnt - d0, N); end
    endtask

    task automatic test_err();
        bit ok;
        clear_log();
        force_zero = 1'b1;
        push_one(1'b1, 8'h5A);
        wait_done(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_first_done_timeout done=%b want 1", DONE); end
        @(posedge CLK); #1;
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", ERR); end
        wait_idle(20, ok);
        checks++;
        if (rf_r2 !== 8'h5A) begin errors++; $display("FAIL err_write_landed r2=%h want 5a", rf_r2); end
        push_one(1'b0, 8'h3C);
        wait_done(20, ok);
        ERR_CLR = 1'b1;
        @(posedge CLK); #1 ERR_CLR = 1'b0;
        checks++;
        if (!ok || ERR !== 1'b1) begin errors++; $display("FAIL err_set_beats_clr got %b want 1 (done seen %0d)", ERR, ok); end
        wait_idle(20, ok);
        force_zero = 1'b0;
        @(posedge CLK); #1 ERR_CLR = 1'b1;
        @(posedge CLK); #1 ERR_CLR = 1'b0;
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", ERR); end
        push_one(1'b0, 8'h77);
        wait_idle(20, ok);
        checks++;
        if (ERR !== 1'b0 || rf_r1 !== 8'h77) begin
            errors++; $display("FAIL err_clean_write err=%b r1=%h want 0 77", ERR, rf_r1);
        end
    endtask

    task automatic test_reset_midop();
        logic [DW:0] vals[4];
        int d0;
        bit ok;
        vals[0] = 9'h012; vals[1] = 9'h0FF; vals[2] = 9'h134; vals[3] = 9'h056;
        clear_log();
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) begin
            REQ_VALID = 1'b1;
            {REQ_SEL, REQ_DATA} = vals[i];
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (RF_WR && RF_DATA == 8'hFF) ok = 1'b1;
        end
        checks++;
        if (!ok || COUNT !== CW'(2)) begin
            errors++; $display("FAIL rst_setup write_seen=%0d cnt=%0d want 1 2", ok, COUNT);
        end
        d0 = done_cnt;
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({RF_WR, DONE, BUSY, REQ_READY} !== 4'b0000 || COUNT !== '0) begin
            errors++; $display("FAIL rst_immediate wr=%b done=%b busy=%b rdy=%b cnt=%0d want all 0",
                               RF_WR, DONE, BUSY, REQ_READY, COUNT);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || done_cnt != d0) begin
            errors++; $display("FAIL rst_no_done done=%b new_dones=%0d want 0 0", DONE, done_cnt - d0);
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== vals[0] || obs_q[1] !== vals[1]) begin
            errors++; $display("FAIL rst_prefix writes=%0d want 2 (012, 0ff)", obs_q.size());
        end
        aborted += exp_q.size() - 1;
        clear_log();
        @(posedge CLK); #1 RST = 1'b0;
        d0 = done_cnt;
        push_one(1'b1, 8'h01);
        wait_idle(20, ok);
        checks++;
        if (!ok || rf_r2 !== 8'h01 || done_cnt - d0 != 1 || ERR !== 1'b0) begin
            errors++; $display("FAIL rst_recover ok=%0d r2=%h dones=%0d err=%b want 1 01 1 0", ok, rf_r2, done_cnt - d0, ERR);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_err();
        test_reset_midop();
        checks++;
        if (consec_viol != 0) begin errors++; $display("FAIL wr_consecutive got %0d want 0", consec_viol); end
        checks++;
        if (rdy_viol != 0) begin errors++; $display("FAIL ready_vs_count got %0d want 0", rdy_viol); end
        checks++;
        if (cnt_viol != 0) begin errors++; $display("FAIL count_model got %0d want 0", cnt_viol); end
        checks++;
        if (done_cnt != acc_cnt - aborted) begin
            errors++; $display("FAIL done_total got %0d want %0d", done_cnt, acc_cnt - aborted);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
